// File: rtl/qupls_fpu_rsq_pkg.sv
// Shared QUPLS types used by the FPU reservation station.
package QuplsPkg;

  localparam int unsigned FPU_RSQ_LANES = 8;

  typedef logic [63:0] value_t;
  localparam value_t value_zero = '0;

  typedef logic [4:0] rob_ndx_t;
  typedef logic [8:0] pregno_t;
  typedef logic [5:0] aregno_t;
  typedef logic [3:0] checkpt_ndx_t;

  typedef enum logic [6:0] {
    OP_NOP  = 7'h0B,
    OP_FLT3 = 7'h52
  } opcode_t;

  typedef struct packed {
    logic [40:0] payload;
    opcode_t     opcode;
  } instruction_t;

  localparam logic [31:0] RSTPC = 32'hFFFD_0000;

  typedef struct packed {
    logic [4:0]  bno_t;
    logic [4:0]  bno_f;
    logic [31:0] pc;
  } pc_address_ex_t;

  typedef struct packed {
    logic    vec;
    logic    multicycle;
    logic    cpytgt;
    aregno_t Ra;
    aregno_t Rt;
    value_t  imm;
  } decode_bus_t;

  typedef struct packed {
    decode_bus_t    decbus;
    instruction_t   op;
    pc_address_ex_t pc;
    pregno_t        nRt;
    checkpt_ndx_t   cndx;
  } rob_entry_t;

  // Copy-target bits live beside the entry so LANES can be overridden per instance.
  typedef struct packed {
    rob_ndx_t   id;
    rob_entry_t rob;
    value_t     argA;
    value_t     argB;
    value_t     argC;
    value_t     argT;
    value_t     argM;
  } fpu_rsq_entry_t;

endpackage

// File: rtl/qupls_fpu_rsq_cptgt.sv
// Per-lane copy-target extraction from the mask operand at dispatch.
module qupls_fpu_rsq_cptgt
  import QuplsPkg::*;
#(
  parameter int unsigned LANES = FPU_RSQ_LANES
)(
  input  logic             vec,
  input  logic             cpytgt,
  input  logic [2:0]       ra,
  input  value_t           argm,
  output logic [LANES-1:0] cptgt
);

  logic [LANES-1:0] lane_mask;

  always_comb begin
    lane_mask = LANES'(argm >> (32'(ra) * LANES));
    cptgt     = {LANES{cpytgt}};
    if (vec)
      cptgt = cptgt | ~lane_mask;
  end

endmodule

// File: rtl/qupls_fpu_rsq.sv
// FPU reservation queue: in-order FIFO of dispatched ops issued when the FPU is idle.
// Define QUPLS_FPU_RSQ_BYPASS_EN to issue straight from dispatch into an empty queue.
module qupls_fpu_rsq
  import QuplsPkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LANES = FPU_RSQ_LANES
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  rob_ndx_t                in_id,
  input  rob_entry_t              in_rob,
  input  value_t                  in_argA,
  input  value_t                  in_argB,
  input  value_t                  in_argC,
  input  value_t                  in_argT,
  input  value_t                  in_argM,
  input  logic                    in_ctagA,
  input  logic                    in_ctagB,
  input  logic                    fu_idle,
  input  logic                    flush,
  output logic                    out_valid,
  output rob_ndx_t                id,
  output value_t                  argA,
  output value_t                  argB,
  output value_t                  argC,
  output value_t                  argT,
  output value_t                  argM,
  output value_t                  argI,
  output pregno_t                 Rt,
  output aregno_t                 aRt,
  output logic                    aRtz,
  output instruction_t            instr,
  output pc_address_ex_t          pc,
  output checkpt_ndx_t            cp,
  output logic [LANES-1:0]        cptgt,
  output logic                    sc_done,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fpu_rsq_entry_t   mem [DEPTH];
  logic [LANES-1:0] mem_cptgt [DEPTH];
  fpu_rsq_entry_t   din, src;
  logic [LANES-1:0] din_cptgt, src_cptgt;
  logic [AW-1:0]    head, tail;
  logic             accept, bypass, issue_q, enq, issue, src_sc_done;
  logic             unused_bits;

  qupls_fpu_rsq_cptgt #(.LANES(LANES)) u_cptgt (
    .vec    (in_rob.decbus.vec),
    .cpytgt (in_rob.decbus.cpytgt),
    .ra     (in_rob.decbus.Ra[2:0]),
    .argm   (in_argM),
    .cptgt  (din_cptgt)
  );

  always_comb begin
    din      = '0;
    din.id   = in_id;
    din.rob  = in_rob;
    din.argA = in_argA;
    din.argB = in_argB;
    din.argC = in_argC;
    din.argT = in_argT;
    din.argM = in_argM;
  end

  assign in_ready = count < FULL;
  assign accept   = in_valid && in_ready && !flush;
`ifdef QUPLS_FPU_RSQ_BYPASS_EN
  assign bypass   = accept && fu_idle && (count == '0);
`else
  assign bypass   = 1'b0;
`endif
  assign issue_q  = fu_idle && (count != '0) && !flush;
  assign enq      = accept && !bypass;
  assign issue    = issue_q || bypass;

  assign src         = bypass ? din : mem[head];
  assign src_cptgt   = bypass ? din_cptgt : mem_cptgt[head];
  assign src_sc_done = !src.rob.decbus.multicycle || (&src_cptgt);

  assign unused_bits = ^{in_ctagA, in_ctagB, src.rob.decbus.vec,
                         src.rob.decbus.cpytgt, src.rob.decbus.Ra};

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i]       <= '0;
        mem_cptgt[i] <= '0;
      end
      out_valid <= 1'b0;
      sc_done   <= 1'b0;
      id        <= '0;
      argA      <= value_zero;
      argB      <= value_zero;
      argC      <= value_zero;
      argT      <= value_zero;
      argM      <= value_zero;
      argI      <= value_zero;
      Rt        <= '0;
      aRt       <= '0;
      aRtz      <= 1'b1;
      instr     <= '{payload: '0, opcode: OP_NOP};
      pc        <= '{bno_t: 5'd1, bno_f: 5'd1, pc: RSTPC};
      cp        <= '0;
      cptgt     <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i]       <= '0;
        mem_cptgt[i] <= '0;
      end
      out_valid <= 1'b0;
      sc_done   <= 1'b0;
    end else begin
      if (enq) begin
        mem[tail]       <= din;
        mem_cptgt[tail] <= din_cptgt;
        tail            <= tail + 1'b1;
      end
      if (issue_q)
        head <= head + 1'b1;
      if (enq && !issue_q)
        count <= count + 1'b1;
      else if (!enq && issue_q)
        count <= count - 1'b1;
      out_valid <= issue;
      sc_done   <= issue && src_sc_done;
      if (issue) begin
        id    <= src.id;
        argA  <= src.argA;
        argB  <= src.argB;
        argC  <= src.argC;
        argT  <= src.argT;
        argM  <= src.argM;
        argI  <= src.rob.decbus.imm;
        Rt    <= src.rob.nRt;
        aRt   <= src.rob.decbus.Rt;
        aRtz  <= (src.rob.decbus.Rt == '0);
        instr <= src.rob.op;
        pc    <= src.rob.pc;
        cp    <= src.rob.cndx;
        cptgt <= src_cptgt;
      end
    end
  end

endmodule
